// File: rtl/regop_pkg.sv
// Shared encodings and types for the register-operation command sequencer.
package regop_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_NOT  = 2'b10,
    OP_SHL  = 2'b11
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Widest repeat count a command record can carry; narrower counts are zero-extended.
  localparam int MAX_CNT_W = 8;
  localparam int DATA_W    = 4;

  typedef struct packed {
    op_t                  op;
    logic [MAX_CNT_W-1:0] cnt;
    logic [DATA_W-1:0]    data;
  } cmd_t;

endpackage

// File: rtl/regop_cmd_fifo.sv
// Command queue: power-of-two depth, extra pointer bit distinguishes full from empty.
module regop_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push while full is refused even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regop_sequencer.sv
// Plays queued register commands into the downstream 4-bit register-ops stage,
// one operation per cycle, holding the register whenever nothing executes.
module regop_sequencer
  import regop_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [3:0]       in_data,
  input  logic [3:0]       reg_o,
  output logic [3:0]       reg_i,
  output logic [1:0]       reg_s,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  // Handshake: a command transfers on any rising edge where in_valid and in_ready
  // are both high; in_ready is low while full and while reset is asserted.

  cmd_t                 cmd_in;
  cmd_t                 head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [3:0]           data_q, data_d;
  logic [MAX_CNT_W-1:0] remaining_q, remaining_d;

  assign cmd_in.op   = op_t'(in_op);
  assign cmd_in.cnt  = MAX_CNT_W'(in_cnt);
  assign cmd_in.data = in_data;

  regop_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata (cmd_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !reset && !fifo_full;
  assign busy      = (state_q == EXEC) || !fifo_empty;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      data_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    pop         = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (remaining_q != '0) begin
          remaining_d = remaining_q - 1'b1;
        end else begin
          done = 1'b1;
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      op_d        = head.op;
      data_d      = head.data;
      remaining_d = (head.op == OP_LOAD) ? '0 : head.cnt;
    end
  end

  // Multi-cycle ops recirculate the register's own output.
  always_comb begin
    reg_s = OP_LOAD;
    reg_i = reg_o;
    if (state_q == EXEC) begin
      reg_s = op_q;
      if (op_q == OP_LOAD) reg_i = data_q;
    end
  end

endmodule

// File: tb/tb_regop_sequencer.sv
// Directed bench for regop_sequencer driving a behavioural 4-bit register-ops stage.
module tb_regop_sequencer;
  import regop_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [1:0] in_cnt;
  logic [3:0] in_data;
  logic [3:0] reg_o;
  logic [3:0] reg_i;
  logic [1:0] reg_s;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  logic [3:0] reg_q = 4'b0000;
  logic [6:0] exp_q[$];
  logic [3:0] exp_reg = 4'b0000;
  int         checks = 0;
  int         failures = 0;
  int         stall_cnt = 0;

  regop_sequencer #(.FIFO_DEPTH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_cnt    (in_cnt),
    .in_data   (in_data),
    .reg_o     (reg_o),
    .reg_i     (reg_i),
    .reg_s     (reg_s),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // downstream register-ops stage (not reset)
  always @(posedge clk) begin
    case (reg_s)
      2'b00: reg_q <= reg_i;
      2'b01: reg_q <= {1'b0, reg_i[3:1]};
      2'b10: reg_q <= ~reg_i;
      default: reg_q <= {reg_i[2:0], 1'b0};
    endcase
  end
  assign reg_o = reg_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] apply_op(input logic [1:0] s, input logic [3:0] i);
    case (s)
      2'b00: apply_op = i;
      2'b01: apply_op = {1'b0, i[3:1]};
      2'b10: apply_op = ~i;
      default: apply_op = {i[2:0], 1'b0};
    endcase
  endfunction

  // driver: called at a falling edge, returns at the falling edge after acceptance
  task automatic push_cmd(input logic [1:0] op, input logic [1:0] cnt, input logic [3:0] data);
    int n;
    int waits;
    n = (op == 2'b00) ? 0 : int'(cnt);
    for (int k = 0; k <= n; k++) begin
      if (op == 2'b00) begin
        exp_q.push_back({(k == n), 2'b00, data});
        exp_reg = data;
      end else begin
        exp_q.push_back({(k == n), op, exp_reg});
        exp_reg = apply_op(op, exp_reg);
      end
    end
    in_valid = 1'b1;
    in_op    = op;
    in_cnt   = cnt;
    in_data  = data;
    waits    = 0;
    while (!in_ready && waits < 200) begin
      stall_cnt++;
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) check("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || dbg_state != IDLE) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_done", 32'(n < 200), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [6:0] e;
    if (!reset) begin
      if (dbg_state == EXEC) begin
        if (exp_q.size() == 0) begin
          check("exec_unexpected", {25'd0, done, reg_s, reg_i}, 32'h7f);
        end else begin
          e = exp_q.pop_front();
          check("exec_cycle", {25'd0, done, reg_s, reg_i}, {25'd0, e});
        end
      end else begin
        check("idle_hold", {25'd0, done, reg_s, reg_i}, {25'd0, 1'b0, 2'b00, reg_o});
      end
    end
  end

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_op    = 2'b00;
    in_cnt   = 2'b00;
    in_data  = 4'b0000;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_reg_s", 32'(reg_s), 32'd0);
    check("rst_reg_i", 32'(reg_i), 32'(reg_o));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // LOAD 1011
    push_cmd(2'b00, 2'b00, 4'b1011);
    drain();
    check("load_reg_o", 32'(reg_o), 32'hb);

    // SHR x2: 0101, 0010
    push_cmd(2'b01, 2'b01, 4'b0000);
    drain();
    check("shr_reg_o", 32'(reg_o), 32'h2);

    // back-to-back SHL x1 then NOT x3: 0100, 1011, 0100, 1011
    push_cmd(2'b11, 2'b00, 4'b0000);
    push_cmd(2'b10, 2'b10, 4'b0000);
    n = 0;
    while (dbg_state == EXEC && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("b2b_exec_cycles", 32'(n), 32'd4);
    drain();
    check("b2b_reg_o", 32'(reg_o), 32'hb);

    // fill and wrap the queue while long commands execute
    push_cmd(2'b00, 2'b00, 4'b1101);
    drain();
    stall_cnt = 0;
    push_cmd(2'b01, 2'b10, 4'b0000);
    push_cmd(2'b10, 2'b11, 4'b0000);
    push_cmd(2'b11, 2'b11, 4'b0000);
    push_cmd(2'b10, 2'b11, 4'b0000);
    push_cmd(2'b01, 2'b11, 4'b0000);
    push_cmd(2'b10, 2'b10, 4'b0000);
    push_cmd(2'b11, 2'b01, 4'b0000);
    check("full_stalled", 32'(stall_cnt > 0), 32'd1);
    drain();
    check("fill_reg_o", 32'(reg_o), 32'hc);

    // reset in second cycle of NOT x4 with two commands queued
    push_cmd(2'b10, 2'b11, 4'b0000);
    push_cmd(2'b00, 2'b00, 4'b0110);
    push_cmd(2'b11, 2'b01, 4'b0000);
    check("pre_rst_exec", 32'(dbg_state), 32'(EXEC));
    check("pre_rst_reg_o", 32'(reg_o), 32'h3);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_reg = 4'b0011;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_reg_s", 32'(reg_s), 32'd0);
    check("mid_rst_reg_i", 32'(reg_i), 32'(reg_o));
    repeat (2) @(negedge clk);
    check("mid_rst_hold", 32'(reg_o), 32'h3);
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_busy", 32'(busy), 32'd0);
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    check("after_rst_reg_s", 32'(reg_s), 32'd0);

    // long idle
    repeat (10) @(negedge clk);
    check("idle_reg_o", 32'(reg_o), 32'h3);
    check("idle_done", 32'(done), 32'd0);
    check("idle_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
